// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM state encoding, image framing
// constants and the header sanity check used when the word count arrives.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CSUM  = 3'd4,
        RUN   = 3'd5,
        ERROR = 3'd6
    } state_t;

    // Two header bytes carry the little-endian word count.
    localparam int HDR_BYTES = 2;

    // Bytes packed into each memory word.
    localparam int WORD_BYTES = 4;

    // Starting value of the running XOR checksum.
    localparam logic [7:0] CSUM_INIT = 8'h00;

    // A word count is usable only if it is non-zero and fits in memory.
    function automatic logic header_ok(input logic [15:0] n, input logic [15:0] max_words);
        return (n != 16'd0) && (n <= max_words);
    endfunction

endpackage

// File: rtl/boot_loader_word_assembler.sv
// Collects four bytes into one little-endian 32-bit word. The first byte of a
// word ends up in bits [7:0] because each new byte enters at the top and the
// older bytes shift down. word_complete pulses with the enable of the 4th byte.
module word_assembler
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_en,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0] byte_idx;

    // Shift each accepted byte in from the top and count bytes within the word.
    always_ff @(posedge clk) begin
        if (reset) begin
            word     <= 32'd0;
            byte_idx <= 2'd0;
        end else if (byte_en) begin
            word     <= {byte_in, word[31:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word_complete = byte_en && (byte_idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/boot_loader.sv
// Program-image loader in front of memory data port 2. It keeps the CPU in
// reset while an image arrives over the byte link, writes each assembled word
// to memory, verifies the trailing XOR checksum and then either hands port 2
// to the CPU (RUN) or parks in ERROR until the next reset.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int NUM_BYTES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] cpu_address2,
    input  logic [31:0] cpu_wdata2,
    input  logic        cpu_we2,
    output logic [31:0] mem_address2,
    output logic [31:0] mem_wdata2,
    output logic        mem_we2,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_error
);

    localparam int          MAX_WORDS   = NUM_BYTES / WORD_BYTES;
    localparam logic [15:0] MAX_WORDS_W = 16'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [15:0] word_idx;
    logic [15:0] n_words;
    logic [7:0]  n_lo;
    logic [7:0]  csum;
    logic        xfer;
    logic        byte_en;
    logic [31:0] word;
    logic        word_complete;

    assign xfer    = rx_valid && rx_ready;
    assign byte_en = xfer && (state == DATA);

    word_assembler u_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .byte_in       (rx_data),
        .byte_en       (byte_en),
        .word          (word),
        .word_complete (word_complete)
    );

    // State register; reset always restarts the image from the header.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HDR0;
        end else begin
            state <= state_next;
        end
    end

    // Header capture, running checksum over all pre-checksum bytes, and the
    // word index that advances once per memory write.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_idx <= 16'd0;
            n_words  <= 16'd0;
            n_lo     <= 8'd0;
            csum     <= CSUM_INIT;
        end else begin
            if (xfer && (state == HDR0 || state == HDR1 || state == DATA)) begin
                csum <= csum ^ rx_data;
            end
            if (xfer && state == HDR0) begin
                n_lo <= rx_data;
            end
            if (xfer && state == HDR1) begin
                n_words <= {rx_data, n_lo};
            end
            if (state == WRITE) begin
                word_idx <= word_idx + 16'd1;
            end
        end
    end

    // Next-state decode; absent a transfer every state holds.
    always_comb begin
        state_next = state;
        case (state)
            HDR0: begin
                if (xfer) state_next = HDR1;
            end
            HDR1: begin
                if (xfer) begin
                    state_next = header_ok({rx_data, n_lo}, MAX_WORDS_W) ? DATA : ERROR;
                end
            end
            DATA: begin
                if (word_complete) state_next = WRITE;
            end
            WRITE: begin
                state_next = ((word_idx + 16'd1) == n_words) ? CSUM : DATA;
            end
            CSUM: begin
                if (xfer) state_next = (rx_data == csum) ? RUN : ERROR;
            end
            RUN:     state_next = RUN;
            ERROR:   state_next = ERROR;
            default: state_next = ERROR;
        endcase
    end

    // Output decode: link handshake, port-2 mux (loader write or CPU
    // pass-through) and the CPU reset / status flags.
    always_comb begin
        rx_ready     = 1'b0;
        mem_address2 = 32'd0;
        mem_wdata2   = 32'd0;
        mem_we2      = 1'b0;
        cpu_reset    = 1'b1;
        load_done    = 1'b0;
        load_error   = 1'b0;
        case (state)
            HDR0, HDR1, DATA, CSUM: begin
                rx_ready = 1'b1;
            end
            WRITE: begin
                mem_we2      = 1'b1;
                mem_address2 = {14'd0, word_idx, 2'b00};
                mem_wdata2   = word;
            end
            RUN: begin
                mem_address2 = cpu_address2;
                mem_wdata2   = cpu_wdata2;
                mem_we2      = cpu_we2;
                cpu_reset    = 1'b0;
                load_done    = 1'b1;
            end
            ERROR: begin
                load_error = 1'b1;
            end
            default: begin
                load_error = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a table of whole images with their expected
// writes and final status, followed by hand-written reset-mid-load and RUN
// pass-through sequences.
module tb_boot_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] cpu_address2;
    logic [31:0] cpu_wdata2;
    logic        cpu_we2;
    logic [31:0] mem_address2;
    logic [31:0] mem_wdata2;
    logic        mem_we2;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int checks   = 0;
    int failures = 0;
    int we_total = 0;

    typedef struct {
        int                nbytes;
        logic [0:11][7:0]  bytes;
        bit                gaps;
        int                nwrites;
        logic [0:1][31:0]  wdata;
        bit                done;
        bit                err;
        bit                ready;
    } vec_t;

    vec_t vecs[7];

    boot_loader #(.NUM_BYTES(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .cpu_address2 (cpu_address2),
        .cpu_wdata2   (cpu_wdata2),
        .cpu_we2      (cpu_we2),
        .mem_address2 (mem_address2),
        .mem_wdata2   (mem_wdata2),
        .mem_we2      (mem_we2),
        .cpu_reset    (cpu_reset),
        .load_done    (load_done),
        .load_error   (load_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count loader-side write pulses so stray or missing writes show up.
    always @(negedge clk) begin
        if (mem_we2 && !load_done) we_total++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_rx_ready", 32'(rx_ready), 32'd1);
        checkOutput("rst_mem_we2", 32'(mem_we2), 32'd0);
        checkOutput("rst_mem_address2", mem_address2, 32'd0);
        checkOutput("rst_mem_wdata2", mem_wdata2, 32'd0);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_load_error", 32'(load_error), 32'd0);
    endtask

    // Offer one byte starting at a negedge; returns at the negedge after it transfers.
    task automatic sendByte(input logic [7:0] b, input bit gaps);
        bit ok;
        ok = 1'b0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 20; t++) begin
            if (rx_ready) begin
                @(negedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!ok) checkOutput("rx_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input bit do_reset);
        int we_start;
        int widx;
        if (do_reset) begin
            doReset();
            checkResetState();
        end
        we_start = we_total;
        for (int i = 0; i < v.nbytes; i++) begin
            sendByte(v.bytes[i], v.gaps);
            if (i >= 2 && ((i - 2) % 4) == 3 && ((i - 2) / 4) < v.nwrites) begin
                widx = (i - 2) / 4;
                checkOutput("wr_we2", 32'(mem_we2), 32'd1);
                checkOutput("wr_addr", mem_address2, 32'(widx * 4));
                checkOutput("wr_data", mem_wdata2, v.wdata[widx]);
                checkOutput("wr_rx_ready", 32'(rx_ready), 32'd0);
            end
        end
        repeat (2) @(negedge clk);
        checkOutput("end_load_done", 32'(load_done), 32'(v.done));
        checkOutput("end_load_error", 32'(load_error), 32'(v.err));
        checkOutput("end_cpu_reset", 32'(cpu_reset), 32'(!v.done));
        checkOutput("end_rx_ready", 32'(rx_ready), 32'(v.ready));
        checkOutput("end_write_count", 32'(we_total - we_start), 32'(v.nwrites));
    endtask

    initial begin
        reset        = 1'b1;
        rx_data      = 8'h00;
        rx_valid     = 1'b0;
        cpu_address2 = 32'h8;
        cpu_wdata2   = 32'hCAFEF00D;
        cpu_we2      = 1'b1;

        // One-word image, checksum 01^00^78^56^34^12 = 09.
        vecs[0] = '{nbytes: 7, bytes: {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09, 40'h0},
                    gaps: 0, nwrites: 1, wdata: {32'h12345678, 32'h0}, done: 1, err: 0, ready: 0};
        // Two words with gaps, checksum 02^EF^BE^AD^DE^01 = 21.
        vecs[1] = '{nbytes: 11, bytes: {8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                                        8'h01, 8'h00, 8'h00, 8'h00, 8'h21, 8'h0},
                    gaps: 1, nwrites: 2, wdata: {32'hDEADBEEF, 32'h00000001}, done: 1, err: 0, ready: 0};
        // N = 0.
        vecs[2] = '{nbytes: 2, bytes: {8'h00, 8'h00, 80'h0},
                    gaps: 0, nwrites: 0, wdata: {32'h0, 32'h0}, done: 0, err: 1, ready: 0};
        // N = 17, one past the memory.
        vecs[3] = '{nbytes: 2, bytes: {8'h11, 8'h00, 80'h0},
                    gaps: 0, nwrites: 0, wdata: {32'h0, 32'h0}, done: 0, err: 1, ready: 0};
        // Good word, wrong checksum.
        vecs[4] = '{nbytes: 7, bytes: {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08, 40'h0},
                    gaps: 0, nwrites: 1, wdata: {32'h12345678, 32'h0}, done: 0, err: 1, ready: 0};
        // N = 16 exactly fits: accepted, waiting for payload.
        vecs[5] = '{nbytes: 2, bytes: {8'h10, 8'h00, 80'h0},
                    gaps: 0, nwrites: 0, wdata: {32'h0, 32'h0}, done: 0, err: 0, ready: 1};
        // N = 0x0101 exercises the high header byte.
        vecs[6] = '{nbytes: 2, bytes: {8'h01, 8'h01, 80'h0},
                    gaps: 1, nwrites: 0, wdata: {32'h0, 32'h0}, done: 0, err: 1, ready: 0};

        for (int v = 0; v < 7; v++) begin
            $display("[TB] vector %0d", v);
            applyStimulus(vecs[v], 1'b1);
        end

        // Reset in the middle of a two-word payload, then a clean one-word image.
        $display("[TB] reset during load");
        doReset();
        sendByte(8'h02, 1'b0);
        sendByte(8'h00, 1'b0);
        sendByte(8'hEF, 1'b0);
        sendByte(8'hBE, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkResetState();
        applyStimulus(vecs[0], 1'b0);

        // RUN pass-through follows the CPU inputs within the same cycle.
        $display("[TB] run pass-through");
        cpu_we2      = 1'b1;
        cpu_address2 = 32'h8;
        cpu_wdata2   = 32'hCAFEF00D;
        #1;
        checkOutput("run_we2", 32'(mem_we2), 32'd1);
        checkOutput("run_addr", mem_address2, 32'h8);
        checkOutput("run_data", mem_wdata2, 32'hCAFEF00D);
        cpu_we2      = 1'b0;
        cpu_address2 = 32'h3C;
        cpu_wdata2   = 32'h0BADF00D;
        #1;
        checkOutput("run_we2_low", 32'(mem_we2), 32'd0);
        checkOutput("run_addr2", mem_address2, 32'h3C);
        checkOutput("run_data2", mem_wdata2, 32'h0BADF00D);
        checkOutput("run_cpu_reset", 32'(cpu_reset), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
